rf_wb_arbiter: RTL
==================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter: RR, default 1, 1 = round-robin between requesters, 0 = fixed priority to requester 0.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on posedge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: issue_valid  in  1  an instruction with destination issue_rd is issued this cycle.
REQ-005 SHALL have port: issue_rd  in  5  destination register of the issued instruction.
REQ-006 SHALL have ports: req0_valid  in  1 / req0_waddr  in  5 / req0_wdata  in  32  writeback request 0 (ALU path).
REQ-007 SHALL have port: req0_ready  out  1  request 0 accepted this cycle.
REQ-008 SHALL have ports: req1_valid  in  1 / req1_waddr  in  5 / req1_wdata  in  32  writeback request 1 (load path).
REQ-009 SHALL have port: req1_ready  out  1  request 1 accepted this cycle.
REQ-010 SHALL have ports: rf_we  out  1 / rf_waddr  out  5 / rf_wdata  out  32  single regfile write port, registered.
REQ-011 SHALL have port: busy  out  32  per-register pending-write scoreboard, registered.

Function
REQ-012 SHALL accept a request (handshake) on any cycle where reqN_valid and reqN_ready are both 1.
REQ-013 SHALL assert at most one of req0_ready, req1_ready per cycle; readys are combinational from valids and the priority state.
REQ-014 SHALL, with only one valid requester, grant that requester in the same cycle (zero-wait acceptance).
REQ-015 SHALL, with both valid and RR=1, grant the requester not granted most recently; priority pointer toggles only on a two-way conflict grant.
REQ-016 SHALL, with both valid and RR=0, always grant requester 0.
REQ-017 SHALL require requesters to hold valid, waddr, wdata stable until accepted; the block does not store unaccepted requests.
REQ-018 SHALL drive rf_we=1, rf_waddr, rf_wdata of the accepted request exactly one cycle after acceptance (latency 1); rf_we=0 in cycles following no acceptance.
REQ-019 SHALL accept a request with waddr=0 normally but drive rf_we=0 in the following cycle (x0 write suppressed).
REQ-020 SHALL set busy[issue_rd] at the posedge where issue_valid=1 and issue_rd!=0.
REQ-021 SHALL clear busy[waddr] at the posedge where a request to waddr is accepted.
REQ-022 SHALL, when set and clear hit the same register at the same edge, leave busy=1 (new producer wins).
REQ-023 SHALL hold busy[0]=0 at all times.
REQ-024 SHALL sustain one write per cycle back-to-back with no bubbles while any requester is valid.
REQ-025 SHALL not check that a written register was busy; a write to a non-busy register still reaches the port.

Reset
REQ-026 SHALL, while rst=1, force rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, priority pointer = requester 0, independent of clk.
REQ-027 SHALL drive req0_ready=req1_ready=0 while rst=1.
REQ-028 SHALL discard a request accepted in the cycle before rst asserts (no rf_we after reset release).
REQ-029 SHALL allow acceptance on the first posedge after rst deasserts.

Verification
REQ-030 SHALL cover: req0_valid=1 waddr=5 wdata=0x1234 alone -> req0_ready=1 that cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234.
REQ-031 SHALL cover: RR=1, both valid for 4 cycles (waddr 1 and 2) -> grants 0,1,0,1; rf_waddr sequence 1,2,1,2 one cycle delayed; RR=0 same stimulus -> grants 0,0,0,0.
REQ-032 SHALL cover: req1 write to x0 with wdata=0xFFFFFFFF -> req1_ready=1, rf_we stays 0 next cycle, busy unchanged.
REQ-033 SHALL cover: issue_rd=7 cycle 0 -> busy[7]=1 from cycle 1; req0 write to 7 cycle 3 -> busy[7]=0 from cycle 4; issue_rd=7 and accepted write to 7 same cycle -> busy[7]=1.
REQ-034 SHALL cover: issue_rd=0 -> busy stays 0.
REQ-035 SHALL cover: accept req0 (waddr 3), assert rst asynchronously mid-cycle -> rf_we, busy, readys 0 immediately; after release no write to 3 appears, next request accepted on first edge.

Source files
------------

// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: issue, two writeback requesters, regfile write port and busy scoreboard; master drives requests, slave is the arbiter
interface rf_wb_arbiter_if;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        req0_valid;
  logic [4:0]  req0_waddr;
  logic [31:0] req0_wdata;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_waddr;
  logic [31:0] req1_wdata;
  logic        req1_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy;
  modport master (
    output issue_valid, issue_rd,
    output req0_valid, req0_waddr, req0_wdata, input req0_ready,
    output req1_valid, req1_waddr, req1_wdata, input req1_ready,
    input  rf_we, rf_waddr, rf_wdata, busy
  );
  modport slave (
    input  issue_valid, issue_rd,
    input  req0_valid, req0_waddr, req0_wdata, output req0_ready,
    input  req1_valid, req1_waddr, req1_wdata, output req1_ready,
    output rf_we, rf_waddr, rf_wdata, busy
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: two-way writeback arbiter (clk, async rst, bus.slave) with registered regfile write port and pending-write busy scoreboard
module rf_wb_arbiter #(
  parameter bit RR = 1'b1
) (
  input logic         clk,
  input logic         rst,
  rf_wb_arbiter_if.slave bus
);
  logic        prio;
  logic        g0, g1, acc;
  logic [4:0]  waddr;
  logic [31:0] wdata, set_m, clr_m;
  always_comb begin
    g0    = !rst && bus.req0_valid && (!bus.req1_valid || !RR || !prio);
    g1    = !rst && bus.req1_valid && !g0;
    acc   = g0 || g1;
    waddr = g1 ? bus.req1_waddr : bus.req0_waddr;
    wdata = g1 ? bus.req1_wdata : bus.req0_wdata;
    clr_m = acc ? (32'd1 << waddr) : '0;
    set_m = bus.issue_valid ? (32'd1 << bus.issue_rd) : '0;
  end
  assign bus.req0_ready = g0;
  assign bus.req1_ready = g1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rf_we    <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
      bus.busy     <= '0;
      prio         <= 1'b0;
    end else begin
      bus.rf_we    <= acc && (waddr != 5'd0);
      bus.rf_waddr <= waddr;
      bus.rf_wdata <= wdata;
      bus.busy     <= ((bus.busy & ~clr_m) | set_m) & ~32'd1;
      if (RR && bus.req0_valid && bus.req1_valid) prio <= g0;
    end
  end
endmodule
